muldiv_ctrl: RTL and testbench
==============================

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 SHALL provide parameter MUL_LAT, default 2, multiplier latency in cycles (legal range 1..15).
REQ-002 SHALL provide clk  input  1  sole clock, all state rising-edge.
REQ-003 SHALL provide resetn  input  1  asynchronous, active-low reset.
REQ-004 SHALL provide op_valid  input  1  EX holds a mul/div instruction this cycle.
REQ-005 SHALL provide op_type  input  2  00 mult, 01 multu, 10 div, 11 divu.
REQ-006 SHALL provide op_a, op_b  input  32 each  source operands (rs, rt).
REQ-007 SHALL provide flush  input  1  annul any accepted or in-flight op.
REQ-008 SHALL provide stallreq  output  1  pipeline stall request, Stop=1.
REQ-009 SHALL provide busy  output  1  state != IDLE.
REQ-010 SHALL provide mul_signed, mul_ina, mul_inb  output  1/32/32  multiplier operands; mul_result  input  64.
REQ-011 SHALL provide div_start, div_signed, div_annul  output  1 each; div_opdata1, div_opdata2  output  32 each; div_result  input  64 {rem,quot}; div_ready  input  1.
REQ-012 SHALL provide hilo_we  output  1; hi_wdata, lo_wdata  output  32 each.

Function
REQ-013 SHALL implement states IDLE, MUL_WAIT, DIV_RUN, DONE; 4-bit latency counter; 64-bit result register.
REQ-014 IDLE, op_valid=1, flush=0 at cycle T: SHALL latch op_a, op_b, op_type; assert stallreq combinationally in T; next state MUL_WAIT (op_type[1]=0, counter=MUL_LAT-1) or DIV_RUN.
REQ-015 MUL_WAIT: SHALL drive mul_ina/mul_inb from latched operands, mul_signed=~op_type[0], stallreq=1; decrement counter; at counter 0 capture mul_result and go DONE; hilo_we therefore in cycle T+MUL_LAT+1.
REQ-016 DIV_RUN: SHALL drive div_opdata1/2 from latched operands, div_signed=~op_type[0], div_start=~div_ready, stallreq=1; on div_ready=1 capture div_result, go DONE; no timeout.
REQ-017 DONE: SHALL assert hilo_we=1 for exactly one cycle, hi_wdata=result[63:32], lo_wdata=result[31:0], stallreq=0; SHALL ignore op_valid (same stalled instruction); next state IDLE.
REQ-018 SHALL hold mul/div operand outputs at 0 and div_start=0 in IDLE and DONE.
REQ-019 flush in MUL_WAIT or DIV_RUN: SHALL go IDLE next cycle, deassert stallreq that cycle, discard result; in DIV_RUN also div_annul=1 that cycle.
REQ-020 flush in DONE: SHALL force hilo_we=0; flush with op_valid in IDLE: op not accepted, stallreq=0.
REQ-021 div_annul SHALL be 0 except per REQ-019; hi/lo_wdata SHALL be 0 when hilo_we=0.

Reset
REQ-022 resetn=0 SHALL immediately force IDLE, counter 0, result and latched operands 0, all outputs 0, independent of clk, including mid-operation.
REQ-023 First op SHALL be accepted on the first rising edge after resetn deasserts.

Configuration
REQ-024 Macro MULDIV_DIVZERO_BYPASS_EN defined: div/divu with op_b=0 SHALL skip DIV_RUN, go IDLE->DONE with hi=op_a, lo=32'hFFFF_FFFF, div_start never asserted.
REQ-025 Macro undefined: op_b=0 SHALL be sent to divider as any other div; result as divider returns.

Verification
REQ-026 MUL_LAT=2, mult op_a=-3, op_b=5 at T, mul_result=64'hFFFF_FFFF_FFFF_FFF1 -> stallreq T..T+2, hilo_we at T+3, hi=FFFF_FFFF, lo=FFFF_FFF1.
REQ-027 divu op_a=100, op_b=7, div_ready high 33 cycles later with div_result={32'd2,32'd14} -> div_start high until ready, then hilo_we, hi=2, lo=14, stallreq low in DONE.
REQ-028 div in flight, flush pulse 5 cycles in -> div_annul=1 that cycle, IDLE next, no hilo_we ever.
REQ-029 resetn low during MUL_WAIT between edges -> all outputs 0 immediately; back-to-back mult after release accepted at first edge.
REQ-030 div op_a=9, op_b=0: macro defined -> DONE next cycle, hi=9, lo=FFFF_FFFF, div_start=0; undefined -> div_start asserted.

Source files
------------

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: HI/LO multiply/divide sequencer; stalls EX while an op runs, writes HI/LO once on completion.
// Optional MULDIV_DIVZERO_BYPASS_EN: divide by zero skips the divider and yields hi=op_a, lo=all ones.
module muldiv_ctrl #(
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        op_valid,
  input  logic [1:0]  op_type,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        flush,
  output logic        stallreq,
  output logic        busy,
  output logic        mul_signed,
  output logic [31:0] mul_ina,
  output logic [31:0] mul_inb,
  input  logic [63:0] mul_result,
  output logic        div_start,
  output logic        div_signed,
  output logic        div_annul,
  output logic [31:0] div_opdata1,
  output logic [31:0] div_opdata2,
  input  logic [63:0] div_result,
  input  logic        div_ready,
  output logic        hilo_we,
  output logic [31:0] hi_wdata,
  output logic [31:0] lo_wdata
);
  typedef enum logic [1:0] {IDLE, MUL_WAIT, DIV_RUN, DONE} state_t;
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] res_q, res_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [1:0]  type_q, type_d;
  logic        accept, zero_div, mul_act, div_act;

  assign accept = state_q == IDLE && op_valid && !flush;
`ifdef MULDIV_DIVZERO_BYPASS_EN
  assign zero_div = op_type[1] && op_b == 32'h0;
`else
  assign zero_div = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    a_d     = a_q;
    b_d     = b_q;
    type_d  = type_q;
    case (state_q)
      IDLE: if (accept) begin
        a_d    = op_a;
        b_d    = op_b;
        type_d = op_type;
        if (!op_type[1]) begin
          state_d = MUL_WAIT;
          cnt_d   = 4'(MUL_LAT - 1);
        end else if (zero_div) begin
          state_d = DONE;
          res_d   = {op_a, 32'hFFFF_FFFF};
        end else state_d = DIV_RUN;
      end
      MUL_WAIT: if (flush) state_d = IDLE;
        else if (cnt_q == 4'd0) begin
          res_d   = mul_result;
          state_d = DONE;
        end else cnt_d = cnt_q - 4'd1;
      DIV_RUN: if (flush) state_d = IDLE;
        else if (div_ready) begin
          res_d   = div_result;
          state_d = DONE;
        end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      res_q   <= 64'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      type_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      a_q     <= a_d;
      b_q     <= b_d;
      type_q  <= type_d;
    end

  // Outputs decode the registered state; flush and div_ready must act within the same cycle.
  assign mul_act     = state_q == MUL_WAIT;
  assign div_act     = state_q == DIV_RUN;
  assign busy        = state_q != IDLE;
  assign stallreq    = accept || ((mul_act || div_act) && !flush);
  assign mul_signed  = mul_act && !type_q[0];
  assign mul_ina     = mul_act ? a_q : 32'h0;
  assign mul_inb     = mul_act ? b_q : 32'h0;
  assign div_start   = div_act && !div_ready && !flush;
  assign div_signed  = div_act && !type_q[0];
  assign div_annul   = div_act && flush;
  assign div_opdata1 = div_act ? a_q : 32'h0;
  assign div_opdata2 = div_act ? b_q : 32'h0;
  assign hilo_we     = state_q == DONE && !flush;
  assign hi_wdata    = hilo_we ? res_q[63:32] : 32'h0;
  assign lo_wdata    = hilo_we ? res_q[31:0] : 32'h0;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: scoreboard bench with behavioural multiplier/divider models around muldiv_ctrl.
module tb_muldiv_ctrl;
  localparam int MUL_LAT = 2;
`ifdef MULDIV_DIVZERO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 0, resetn = 0;
  logic op_valid = 0, flush = 0;
  logic [1:0] op_type = 0;
  logic [31:0] op_a = 0, op_b = 0;
  logic stallreq, busy, mul_signed, div_start, div_signed, div_annul, hilo_we;
  logic [31:0] mul_ina, mul_inb, div_opdata1, div_opdata2, hi_wdata, lo_wdata;
  logic [63:0] mul_result, div_result;
  logic div_ready;

  muldiv_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .resetn(resetn), .op_valid(op_valid), .op_type(op_type), .op_a(op_a), .op_b(op_b),
    .flush(flush), .stallreq(stallreq), .busy(busy), .mul_signed(mul_signed), .mul_ina(mul_ina),
    .mul_inb(mul_inb), .mul_result(mul_result), .div_start(div_start), .div_signed(div_signed),
    .div_annul(div_annul), .div_opdata1(div_opdata1), .div_opdata2(div_opdata2),
    .div_result(div_result), .div_ready(div_ready), .hilo_we(hilo_we), .hi_wdata(hi_wdata),
    .lo_wdata(lo_wdata));

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {logic [63:0] res; bit is_mul; int at;} exp_t;
  exp_t sb[$];

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  // HI:LO result an instruction must produce; divide by zero returns {a, all ones}.
  function automatic logic [63:0] model(input logic [1:0] t, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb2, q, r;
    logic [63:0] qq, rr;
    sa = $signed(a);
    sb2 = $signed(b);
    if (t == 2'd0) return 64'(sa * sb2);
    if (t == 2'd1) return {32'h0, a} * {32'h0, b};
    if (b == 32'h0) return {a, 32'hFFFF_FFFF};
    if (t == 2'd2) begin
      q = sa / sb2;
      r = sa % sb2;
      qq = 64'(q);
      rr = 64'(r);
      return {rr[31:0], qq[31:0]};
    end
    return {a % b, a / b};
  endfunction

  // Ideal multiplier: operands are held constant while the controller waits.
  always_comb mul_result = 64'($signed({mul_signed & mul_ina[31], mul_ina}) * $signed({mul_signed & mul_inb[31], mul_inb}));

  // Iterative divider stand-in with programmable latency.
  int next_lat = 10;
  int dcnt;
  bit dbusy, ds;
  logic [31:0] d1, d2;
  always @(posedge clk or negedge resetn)
    if (!resetn) begin
      dbusy <= 0; div_ready <= 0; div_result <= 0; dcnt <= 0; ds <= 0; d1 <= 0; d2 <= 0;
    end else begin
      div_ready <= 0;
      if (div_annul) dbusy <= 0;
      else if (dbusy) begin
        if (dcnt == 0) begin
          div_ready <= 1;
          div_result <= model({1'b1, ~ds}, d1, d2);
          dbusy <= 0;
        end else dcnt <= dcnt - 1;
      end else if (div_start) begin
        dbusy <= 1; dcnt <= next_lat; d1 <= div_opdata1; d2 <= div_opdata2; ds <= div_signed;
      end
    end

  // Monitor: every HI/LO write must match the oldest outstanding expectation.
  always @(negedge clk) if (resetn) begin
    if (hilo_we) begin
      if (sb.size() == 0) chk("unexpected_hilo_we", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("hi", hi_wdata, e.res[63:32]);
        chk("lo", lo_wdata, e.res[31:0]);
        if (e.is_mul) chk("mul_wb_cycle", cyc, e.at);
      end
    end else chk("wdata_zero_when_idle", {hi_wdata, lo_wdata}, 0);
  end

  task automatic wait_idle();
    for (int i = 0; i < 200 && busy; i++) @(posedge clk) #1;
    chk("idle_timeout", busy, 0);
  endtask

  // Called at posedge+1; op presented for one cycle, optional flush in the following cycle.
  task automatic issue(input logic [1:0] t, input logic [31:0] a, input logic [31:0] b, input bit fl);
    exp_t e;
    op_valid = 1; op_type = t; op_a = a; op_b = b;
    #1 chk("stall_on_accept", stallreq, 1);
    if (!fl) begin
      e.res = model(t, a, b);
      e.is_mul = !t[1];
      e.at = cyc + MUL_LAT + 1;
      sb.push_back(e);
    end
    @(posedge clk) #1;
    op_valid = 0;
    chk("busy_after_accept", busy, 1);
    if (t[1]) chk("div_start", div_start, (BYP && b == 0) ? 0 : 1);
    if (fl) begin
      flush = 1;
      #1 chk("stall_drop_on_flush", stallreq, 0);
      @(posedge clk) #1 flush = 0;
      chk("idle_after_flush", busy, 0);
    end else wait_idle();
  endtask

  initial begin
    #2 chk("reset_outputs", {stallreq, busy, hilo_we, div_start, div_annul, mul_ina, div_opdata1}, 0);
    @(posedge clk) #3 resetn = 1;
    @(posedge clk) #1;
    issue(2'd0, 32'hFFFF_FFFD, 32'd5, 0);
    next_lat = 33;
    issue(2'd3, 32'd100, 32'd7, 0);
    issue(2'd2, 32'd9, 32'd0, 0);
    issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    // Flush a divide five cycles into its run.
    next_lat = 20;
    op_valid = 1; op_type = 2'd2; op_a = 32'd1234; op_b = 32'd11;
    @(posedge clk) #1 op_valid = 0;
    repeat (4) @(posedge clk) #1;
    flush = 1;
    #1 chk("div_annul_on_flush", div_annul, 1);
    chk("stall_low_on_flush", stallreq, 0);
    @(posedge clk) #1 flush = 0;
    chk("idle_after_div_flush", busy, 0);
    chk("annul_cleared", div_annul, 0);
    repeat (30) @(posedge clk) #1;
    // Asynchronous reset in the middle of a multiply.
    op_valid = 1; op_type = 2'd1; op_a = 32'd77; op_b = 32'd3;
    @(posedge clk) #1 op_valid = 0;
    #2 resetn = 0;
    #1 chk("async_reset_outputs", {stallreq, busy, mul_signed, mul_ina, mul_inb, hilo_we}, 0);
    @(posedge clk) #1 resetn = 1;
    issue(2'd0, 32'd6, 32'hFFFF_FFF9, 0);
    issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    for (int i = 0; i < 40; i++) begin
      logic [1:0] t;
      logic [31:0] a, b;
      t = 2'($urandom_range(0, 3));
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'h0;
        1: b = $urandom_range(1, 20);
        default: b = $urandom;
      endcase
      next_lat = $urandom_range(2, 40);
      issue(t, a, b, $urandom_range(0, 7) == 0);
      repeat ($urandom_range(0, 2)) @(posedge clk) #1;
    end
    repeat (5) @(posedge clk) #1;
    chk("scoreboard_drained", 64'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
